// File: rtl/wb_completion_tracker.sv
// Writeback/commit tracker for a circular active list: allocates entries at the tail,
// marks them done on writeback, and retires up to two in-order entries per cycle from the head.
module wb_completion_tracker #(
  parameter int AL_DEPTH = 16,
  parameter int AL_LOG   = 4,
  parameter int WB_FLAGS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 dispatchCount_i,
  output logic                       dispatchReady_o,
  output logic [AL_LOG-1:0]          dispatchIdx_o,
  input  logic                       writebkValid0_i,
  input  logic                       writebkValid1_i,
  input  logic                       writebkValid2_i,
  input  logic                       writebkValid3_i,
  input  logic [AL_LOG+WB_FLAGS-1:0] ctrlFU0_i,
  input  logic [AL_LOG+WB_FLAGS-1:0] ctrlFU1_i,
  input  logic [AL_LOG+WB_FLAGS-1:0] ctrlFU2_i,
  input  logic [AL_LOG+WB_FLAGS-1:0] ctrlFU3_i,
  output logic [1:0]                 commitValid_o,
  output logic [AL_LOG-1:0]          commitIdx0_o,
  output logic [AL_LOG-1:0]          commitIdx1_o,
  output logic [WB_FLAGS-1:0]        commitFlags0_o,
  output logic [WB_FLAGS-1:0]        commitFlags1_o,
  output logic                       exception_o,
  output logic [AL_LOG-1:0]          exceptionIdx_o,
  output logic                       strayWb_o,
  output logic [AL_LOG:0]            activeCount_o
);

  localparam int CW = AL_LOG + WB_FLAGS;
  localparam logic [AL_LOG:0] DEPTH_C = (AL_LOG+1)'(AL_DEPTH);

  logic [AL_DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [WB_FLAGS-1:0] flags_q [AL_DEPTH];
  logic [WB_FLAGS-1:0] flags_d [AL_DEPTH];
  logic [AL_LOG-1:0]   head_q, head_d, tail_q, tail_d, head1_s, tail1_s;
  logic [AL_LOG:0]     count_q, count_d;
  logic                stray_q, stray_d;

  logic [3:0]          wb_v_s;
  logic [CW-1:0]       wb_c_s   [4];
  logic [AL_LOG-1:0]   wb_idx_s [4];
  logic [1:0]          disp_cnt_s, cmt_cnt_s;
  logic                head_done_s, exc_s, c0_s, c1_s, ready_s, accept_s;

  assign wb_v_s    = {writebkValid3_i, writebkValid2_i, writebkValid1_i, writebkValid0_i};
  assign wb_c_s[0] = ctrlFU0_i;
  assign wb_c_s[1] = ctrlFU1_i;
  assign wb_c_s[2] = ctrlFU2_i;
  assign wb_c_s[3] = ctrlFU3_i;

  // Head status, commit/exception decisions and dispatch admission from registered state
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      wb_idx_s[p] = wb_c_s[p][CW-1:WB_FLAGS];
    end
    head1_s     = head_q + AL_LOG'(1);
    tail1_s     = tail_q + AL_LOG'(1);
    head_done_s = valid_q[head_q] & done_q[head_q];
    exc_s       = head_done_s & flags_q[head_q][0];
    c0_s        = head_done_s & ~flags_q[head_q][0];
    c1_s        = c0_s & valid_q[head1_s] & done_q[head1_s] & ~flags_q[head1_s][0];
    cmt_cnt_s   = {1'b0, c0_s} + {1'b0, c1_s};
    disp_cnt_s  = (dispatchCount_i == 2'd3) ? 2'd0 : dispatchCount_i;
    ready_s     = ((DEPTH_C - count_q) >= (AL_LOG+1)'(disp_cnt_s)) && !exc_s;
    accept_s    = ready_s && (disp_cnt_s != 2'd0);
  end

  // Next-state: flush on exception, else writeback -> commit clear -> dispatch allocate
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    flags_d = flags_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stray_d = 1'b0;
    if (exc_s) begin
      valid_d = '0;
      done_d  = '0;
      for (int i = 0; i < AL_DEPTH; i++) begin
        flags_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (wb_v_s[p] && valid_q[wb_idx_s[p]]) begin
          done_d[wb_idx_s[p]]  = 1'b1;
          flags_d[wb_idx_s[p]] = flags_d[wb_idx_s[p]] | wb_c_s[p][WB_FLAGS-1:0];
        end else if (wb_v_s[p]) begin
          stray_d = 1'b1;
        end else begin
          stray_d = stray_d;
        end
      end
      if (c0_s) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end else begin
        head_d = head_q;
      end
      if (c1_s) begin
        valid_d[head1_s] = 1'b0;
        done_d[head1_s]  = 1'b0;
      end else begin
        head_d = head_q;
      end
      head_d = head_q + AL_LOG'(cmt_cnt_s);
      if (accept_s) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        flags_d[tail_q] = '0;
        if (disp_cnt_s == 2'd2) begin
          valid_d[tail1_s] = 1'b1;
          done_d[tail1_s]  = 1'b0;
          flags_d[tail1_s] = '0;
        end else begin
          tail_d = tail_q;
        end
        tail_d  = tail_q + AL_LOG'(disp_cnt_s);
        count_d = count_q + (AL_LOG+1)'(disp_cnt_s) - (AL_LOG+1)'(cmt_cnt_s);
      end else begin
        count_d = count_q - (AL_LOG+1)'(cmt_cnt_s);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < AL_DEPTH; i++) begin
        flags_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stray_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stray_q <= stray_d;
    end
  end

  assign dispatchReady_o = ready_s;
  assign dispatchIdx_o   = tail_q;
  assign commitValid_o   = {c1_s, c0_s};
  assign commitIdx0_o    = head_q;
  assign commitIdx1_o    = head1_s;
  assign commitFlags0_o  = flags_q[head_q];
  assign commitFlags1_o  = flags_q[head1_s];
  assign exception_o     = exc_s;
  assign exceptionIdx_o  = exc_s ? head_q : '0;
  assign strayWb_o       = stray_q;
  assign activeCount_o   = count_q;

endmodule

// File: tb/tb_wb_completion_tracker.sv
// Randomized bench for wb_completion_tracker against an in-order queue model of the active list.
module tb_wb_completion_tracker;
  localparam int D = 16;
  localparam int L = 4;
  localparam int F = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       dc;
  logic [3:0]       wv;
  logic [L+F-1:0]   cf [4];
  logic             ready;
  logic [L-1:0]     didx, cidx0, cidx1, eidx;
  logic [1:0]       cvalid;
  logic [F-1:0]     cfl0, cfl1;
  logic             exc, stray;
  logic [L:0]       acount;

  wb_completion_tracker #(.AL_DEPTH(D), .AL_LOG(L), .WB_FLAGS(F)) dut (
    .clk(clk), .reset(reset),
    .dispatchCount_i(dc), .dispatchReady_o(ready), .dispatchIdx_o(didx),
    .writebkValid0_i(wv[0]), .writebkValid1_i(wv[1]),
    .writebkValid2_i(wv[2]), .writebkValid3_i(wv[3]),
    .ctrlFU0_i(cf[0]), .ctrlFU1_i(cf[1]), .ctrlFU2_i(cf[2]), .ctrlFU3_i(cf[3]),
    .commitValid_o(cvalid), .commitIdx0_o(cidx0), .commitIdx1_o(cidx1),
    .commitFlags0_o(cfl0), .commitFlags1_o(cfl1),
    .exception_o(exc), .exceptionIdx_o(eidx), .strayWb_o(stray),
    .activeCount_o(acount)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: ordered list of live indices plus per-index done/flags
  int         q[$];
  bit         mdone [D];
  bit [F-1:0] mflg  [D];
  int         mtail = 0;
  bit         mstray = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_list(input int idx);
    foreach (q[i]) if (q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < D; i++) begin
      mdone[i] = 1'b0;
      mflg[i]  = '0;
    end
    mtail  = 0;
    mstray = 1'b0;
  endtask

  task automatic step(input logic rst_n, input logic [1:0] d, input logic [3:0] v,
                      input logic [L+F-1:0] k0, k1, k2, k3);
    bit e, c0, c1, rdy, st;
    int de, idx;
    logic [L+F-1:0] k [4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    @(negedge clk);
    reset = rst_n; dc = d; wv = v;
    for (int p = 0; p < 4; p++) cf[p] = k[p];
    #1;
    de  = (d == 2'd3) ? 0 : int'(d);
    e   = q.size() > 0 && mdone[q[0]] && mflg[q[0]][0];
    c0  = q.size() > 0 && mdone[q[0]] && !mflg[q[0]][0];
    c1  = c0 && q.size() > 1 && mdone[q[1]] && !mflg[q[1]][0];
    rdy = (D - q.size()) >= de && !e;
    check_eq("commitValid", 32'(cvalid), 32'({c1, c0}));
    check_eq("exception", 32'(exc), 32'(e));
    check_eq("exceptionIdx", 32'(eidx), e ? q[0] : 0);
    check_eq("dispatchReady", 32'(ready), 32'(rdy));
    check_eq("dispatchIdx", 32'(didx), mtail);
    check_eq("activeCount", 32'(acount), q.size());
    check_eq("strayWb", 32'(stray), 32'(mstray));
    if (c0) begin
      check_eq("commitIdx0", 32'(cidx0), q[0]);
      check_eq("commitFlags0", 32'(cfl0), 32'(mflg[q[0]]));
    end
    if (c1) begin
      check_eq("commitIdx1", 32'(cidx1), q[1]);
      check_eq("commitFlags1", 32'(cfl1), 32'(mflg[q[1]]));
    end
    // Apply what the coming edge does
    if (!rst_n) begin
      model_clear();
    end else if (e) begin
      model_clear();
    end else begin
      st = 1'b0;
      for (int p = 0; p < 4; p++) begin
        if (v[p]) begin
          idx = int'(k[p][L+F-1:F]);
          if (in_list(idx)) begin
            mdone[idx] = 1'b1;
            mflg[idx]  = mflg[idx] | k[p][F-1:0];
          end else begin
            st = 1'b1;
          end
        end
      end
      mstray = st;
      if (c0) void'(q.pop_front());
      if (c1) void'(q.pop_front());
      if (rdy) begin
        for (int n = 0; n < de; n++) begin
          q.push_back(mtail);
          mdone[mtail] = 1'b0;
          mflg[mtail]  = '0;
          mtail = (mtail + 1) % D;
        end
      end
    end
  endtask

  function automatic logic [L+F-1:0] ctl(input int idx, input int fl);
    return {L'(idx), F'(fl)};
  endfunction

  initial begin
    logic [L+F-1:0] k [4];
    logic [3:0] v;
    int pwb, tgt, fl;
    reset = 1'b0; dc = 2'd0; wv = 4'd0;
    for (int p = 0; p < 4; p++) cf[p] = '0;
    repeat (2) @(posedge clk);
    model_clear();

    // Reset state, then a pair of double dispatches and out-of-order writebacks
    step(1'b0, 2'd0, 4'd0, 0, 0, 0, 0);
    step(1'b1, 2'd2, 4'd0, 0, 0, 0, 0);
    step(1'b1, 2'd2, 4'd0, 0, 0, 0, 0);
    step(1'b1, 2'd0, 4'b0001, ctl(1, 0), 0, 0, 0);
    step(1'b1, 2'd0, 4'b0001, ctl(0, 0), 0, 0, 0);
    step(1'b1, 2'd0, 4'b0101, ctl(2, 2), 0, ctl(2, 4), 0);
    step(1'b1, 2'd0, 4'b0001, ctl(9, 0), 0, 0, 0);
    step(1'b1, 2'd0, 4'b0000, 0, 0, 0, 0);
    step(1'b1, 2'd3, 4'b0010, 0, ctl(3, 1), 0, 0);
    step(1'b1, 2'd0, 4'b0000, 0, 0, 0, 0);
    step(1'b1, 2'd0, 4'b0000, 0, 0, 0, 0);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      pwb = ((cyc / 300) % 3 == 0) ? 4 : 45;
      for (int p = 0; p < 4; p++) begin
        v[p] = ($urandom_range(0, 99) < pwb);
        if (q.size() > 0 && $urandom_range(0, 9) != 0)
          tgt = q[$urandom_range(0, q.size() - 1)];
        else
          tgt = int'($urandom_range(0, D - 1));
        fl = int'($urandom_range(0, 15)) & 14;
        if ($urandom_range(0, 59) == 0) fl = fl | 1;
        k[p] = ctl(tgt, fl);
      end
      step(($urandom_range(0, 499) != 0), 2'($urandom_range(0, 3)), v, k[0], k[1], k[2], k[3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
